// File: rtl/pcim_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pcim_wr_arbiter
// Description : Shares one PCIM AXI write master among NUM_REQ requesters.
//               Round-robin grant per burst, W channel locked to the winner
//               until wlast, B responses routed back by bid, and a global
//               cap on bursts awaiting a write response.
// Revision    : 1.0 - initial release
// ============================================================================
module pcim_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int MAX_OUT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [NUM_REQ-1:0]     req_cmd_valid_i,
    output logic [NUM_REQ-1:0]     req_cmd_ready_o,
    input  logic [NUM_REQ*40-1:0]  req_cmd_addr_i,
    input  logic [NUM_REQ*8-1:0]   req_cmd_len_i,
    input  logic [NUM_REQ-1:0]     req_pkt_valid_i,
    input  logic [NUM_REQ*512-1:0] req_pkt_data_i,
    output logic [NUM_REQ-1:0]     req_pkt_ready_o,
    output logic [NUM_REQ-1:0]     req_bresp_valid_o,
    output logic [1:0]             req_bresp_o,

    output logic [15:0]            cl_sh_pcim_awid_o,
    output logic [63:0]            cl_sh_pcim_awaddr_o,
    output logic [7:0]             cl_sh_pcim_awlen_o,
    output logic [2:0]             cl_sh_pcim_awsize_o,
    output logic [18:0]            cl_sh_pcim_awuser_o,
    output logic                   cl_sh_pcim_awvalid_o,
    input  logic                   sh_cl_pcim_awready_i,

    output logic [511:0]           cl_sh_pcim_wdata_o,
    output logic [63:0]            cl_sh_pcim_wstrb_o,
    output logic                   cl_sh_pcim_wlast_o,
    output logic                   cl_sh_pcim_wvalid_o,
    input  logic                   sh_cl_pcim_wready_i,

    input  logic [15:0]            sh_cl_pcim_bid_i,
    input  logic [1:0]             sh_cl_pcim_bresp_i,
    input  logic                   sh_cl_pcim_bvalid_i,
    output logic                   cl_sh_pcim_bready_o,

    output logic [5:0]             out_cnt_o,
    output logic                   err_bad_bid_o
);

    localparam logic [5:0] c_MAX_OUT = 6'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   gnt_q;
    logic [39:0]        addr_q;
    logic [7:0]         len_q;
    logic [7:0]         beat_cnt_q;
    logic               awvalid_q;
    logic               bready_q;
    logic [5:0]         out_cnt_q;
    logic [5:0]         out_cnt_d;
    logic               err_q;
    logic               err_d;

    logic [IDX_W-1:0]   w_gnt_idx;
    logic [39:0]        w_sel_addr;
    logic [7:0]         w_sel_len;
    logic               w_can_grant;
    logic               w_sel_pkt_valid;
    logic [511:0]       w_sel_pkt_data;
    logic               w_in_data;
    logic               w_aw_fire;
    logic               w_w_fire;
    logic               w_b_fire;
    logic               w_bid_ok;
    logic               w_has_out;
    logic               w_b_route;
    logic               w_b_dec;

    // Round-robin pick: the valid requester closest at-or-after rr_ptr wins.
    always_comb begin : p_pick
        int v_best;
        int v_dist;
        v_best    = NUM_REQ;
        v_dist    = 0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i >= int'(rr_ptr_q)) begin
                v_dist = i - int'(rr_ptr_q);
            end else begin
                v_dist = i + NUM_REQ - int'(rr_ptr_q);
            end
            if (req_cmd_valid_i[i] && (v_dist < v_best)) begin
                v_best    = v_dist;
                w_gnt_idx = IDX_W'(i);
            end
        end
    end

    // Command fields of the requester being granted this cycle.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_addr = req_cmd_addr_i[i*40 +: 40];
                w_sel_len  = req_cmd_len_i[i*8 +: 8];
            end
        end
    end

    // Data stream of the requester that owns the current burst.
    always_comb begin
        w_sel_pkt_valid = 1'b0;
        w_sel_pkt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == IDX_W'(i)) begin
                w_sel_pkt_valid = req_pkt_valid_i[i];
                w_sel_pkt_data  = req_pkt_data_i[i*512 +: 512];
            end
        end
    end

    // bready_q doubles as the "out of reset" flag so no grant is issued while
    // the reset is still being released.
    assign w_can_grant = (state_q == S_IDLE) && bready_q &&
                         (out_cnt_q < c_MAX_OUT) && (|req_cmd_valid_i);
    assign w_in_data   = (state_q == S_DATA);
    assign w_aw_fire   = awvalid_q && sh_cl_pcim_awready_i;
    assign w_w_fire    = cl_sh_pcim_wvalid_o && sh_cl_pcim_wready_i;

    // Responses are only legal for an in-range requester index while bursts
    // are outstanding; anything else is dropped and flagged.
    assign w_b_fire    = sh_cl_pcim_bvalid_i && bready_q;
    assign w_bid_ok    = (sh_cl_pcim_bid_i[15:IDX_W] == '0) &&
                         (int'(sh_cl_pcim_bid_i[IDX_W-1:0]) < NUM_REQ);
    assign w_has_out   = (out_cnt_q != 6'd0);
    assign w_b_route   = w_b_fire && w_bid_ok && w_has_out;
    assign w_b_dec     = w_b_fire && w_has_out;

    // Per-requester handshake strobes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cmd_ready_o[i]   = w_can_grant && (w_gnt_idx == IDX_W'(i));
            req_pkt_ready_o[i]   = w_in_data && sh_cl_pcim_wready_i &&
                                   (gnt_q == IDX_W'(i));
            req_bresp_valid_o[i] = w_b_route &&
                                   (sh_cl_pcim_bid_i[IDX_W-1:0] == IDX_W'(i));
        end
    end

    assign req_bresp_o          = sh_cl_pcim_bresp_i;

    assign cl_sh_pcim_awid_o    = 16'(gnt_q);
    assign cl_sh_pcim_awaddr_o  = {18'h0, addr_q, 6'h0};
    assign cl_sh_pcim_awlen_o   = len_q;
    assign cl_sh_pcim_awsize_o  = 3'b110;
    assign cl_sh_pcim_awuser_o  = '0;
    assign cl_sh_pcim_awvalid_o = awvalid_q;

    assign cl_sh_pcim_wdata_o   = w_sel_pkt_data;
    assign cl_sh_pcim_wstrb_o   = {64{1'b1}};
    assign cl_sh_pcim_wvalid_o  = w_in_data && w_sel_pkt_valid;
    assign cl_sh_pcim_wlast_o   = w_in_data && (beat_cnt_q == 8'd0);
    assign cl_sh_pcim_bready_o  = bready_q;

    assign out_cnt_o            = out_cnt_q;
    assign err_bad_bid_o        = err_q;

    // Outstanding-burst counter and sticky error next-state.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (w_aw_fire && !w_b_dec) begin
            out_cnt_d = out_cnt_q + 6'd1;
        end else if (!w_aw_fire && w_b_dec) begin
            out_cnt_d = out_cnt_q - 6'd1;
        end
        err_d = err_q | (w_b_fire && (!w_bid_ok || !w_has_out));
    end

    // Burst sequencer: grant, address phase, then data until wlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            awvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            bready_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (w_can_grant) begin
                        gnt_q     <= w_gnt_idx;
                        addr_q    <= w_sel_addr;
                        len_q     <= w_sel_len;
                        awvalid_q <= 1'b1;
                        state_q   <= S_ADDR;
                        if (int'(w_gnt_idx) == NUM_REQ - 1) begin
                            rr_ptr_q <= '0;
                        end else begin
                            rr_ptr_q <= w_gnt_idx + IDX_W'(1);
                        end
                    end
                end
                S_ADDR: begin
                    if (sh_cl_pcim_awready_i) begin
                        awvalid_q  <= 1'b0;
                        beat_cnt_q <= len_q;
                        state_q    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_w_fire) begin
                        if (beat_cnt_q == 8'd0) begin
                            state_q <= S_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    awvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding count and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcim_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pcim_wr_arbiter
// Description : Directed scenarios plus randomized traffic for
//               pcim_wr_arbiter, checked every cycle against a
//               transaction-level model of grants, bursts and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcim_wr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]     cmd_valid, cmd_ready, pkt_valid, pkt_ready, bresp_valid;
    logic [N*40-1:0]  cmd_addr;
    logic [N*8-1:0]   cmd_len;
    logic [N*512-1:0] pkt_data;
    logic [1:0]       req_bresp;
    logic [15:0]      awid;
    logic [63:0]      awaddr;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [18:0]      awuser;
    logic             awvalid, awready;
    logic [511:0]     wdata;
    logic [63:0]      wstrb;
    logic             wlast, wvalid, wready;
    logic [15:0]      bid;
    logic [1:0]       bresp;
    logic             bvalid, bready;
    logic [5:0]       out_cnt;
    logic             err_bad_bid;

    pcim_wr_arbiter #(.NUM_REQ(N), .IDX_W(IW), .MAX_OUT(MO)) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_cmd_valid_i      (cmd_valid),
        .req_cmd_ready_o      (cmd_ready),
        .req_cmd_addr_i       (cmd_addr),
        .req_cmd_len_i        (cmd_len),
        .req_pkt_valid_i      (pkt_valid),
        .req_pkt_data_i       (pkt_data),
        .req_pkt_ready_o      (pkt_ready),
        .req_bresp_valid_o    (bresp_valid),
        .req_bresp_o          (req_bresp),
        .cl_sh_pcim_awid_o    (awid),
        .cl_sh_pcim_awaddr_o  (awaddr),
        .cl_sh_pcim_awlen_o   (awlen),
        .cl_sh_pcim_awsize_o  (awsize),
        .cl_sh_pcim_awuser_o  (awuser),
        .cl_sh_pcim_awvalid_o (awvalid),
        .sh_cl_pcim_awready_i (awready),
        .cl_sh_pcim_wdata_o   (wdata),
        .cl_sh_pcim_wstrb_o   (wstrb),
        .cl_sh_pcim_wlast_o   (wlast),
        .cl_sh_pcim_wvalid_o  (wvalid),
        .sh_cl_pcim_wready_i  (wready),
        .sh_cl_pcim_bid_i     (bid),
        .sh_cl_pcim_bresp_i   (bresp),
        .sh_cl_pcim_bvalid_i  (bvalid),
        .cl_sh_pcim_bready_o  (bready),
        .out_cnt_o            (out_cnt),
        .err_bad_bid_o        (err_bad_bid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*512-1:0] rand_data();
        logic [N*512-1:0] r;
        for (int i = 0; i < N*16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model: one burst at a time, counted in beats sent.
    // ------------------------------------------------------------------
    bit          m_live;
    int          m_ptr, m_out;
    bit          m_err;
    bit          m_active, m_aw_done;
    int          m_sent, m_len, m_owner;
    logic [39:0] m_addr;

    always @(negedge clk) begin : p_model
        logic [N-1:0] e_cr, e_pr, e_bv;
        int  g;
        bit  e_aw, e_wv, e_wl, b_fire, aw_fire, w_fire, dec;
        if (!rst_n) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_pkt_ready", pkt_ready, 0);
            chk("rst_bresp_valid", bresp_valid, 0);
            chk("rst_awvalid", awvalid, 0);
            chk("rst_wvalid", wvalid, 0);
            chk("rst_wlast", wlast, 0);
            chk("rst_bready", bready, 0);
            chk("rst_out_cnt", out_cnt, 0);
            chk("rst_err", err_bad_bid, 0);
            m_live = 0; m_ptr = 0; m_out = 0; m_err = 0;
            m_active = 0; m_aw_done = 0; m_sent = 0; m_len = 0; m_owner = 0;
        end else begin
            g = -1;
            if (m_live && !m_active && m_out < MO) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && cmd_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            e_cr = '0;
            if (g >= 0) e_cr[g] = 1'b1;
            e_aw = m_active && !m_aw_done;
            e_wv = m_active && m_aw_done && pkt_valid[m_owner];
            e_wl = m_active && m_aw_done && (m_sent == m_len);
            e_pr = '0;
            if (m_active && m_aw_done && wready) e_pr[m_owner] = 1'b1;
            b_fire = bvalid && m_live;
            e_bv = '0;
            if (b_fire && m_out > 0 && bid < N) e_bv[bid] = 1'b1;

            chk("cmd_ready", cmd_ready, e_cr);
            chk("awvalid", awvalid, e_aw);
            chk("wvalid", wvalid, e_wv);
            chk("wlast", wlast, e_wl);
            chk("pkt_ready", pkt_ready, e_pr);
            chk("bresp_valid", bresp_valid, e_bv);
            chk("bready", bready, m_live);
            chk("out_cnt", out_cnt, m_out);
            chk("err_bad_bid", err_bad_bid, m_err);
            if (e_aw) begin
                chk("awaddr", awaddr, {18'h0, m_addr, 6'h0});
                chk("awlen", awlen, m_len);
                chk("awid", awid, m_owner);
                chk("awsize", awsize, 3'b110);
                chk("awuser", awuser, 0);
            end
            if (e_wv) begin
                chk("wdata", wdata, pkt_data[m_owner*512 +: 512]);
                chk("wstrb", wstrb, {64{1'b1}});
            end
            if (e_bv != 0) chk("req_bresp", req_bresp, bresp);

            aw_fire = e_aw && awready;
            w_fire  = e_wv && wready;
            dec     = b_fire && m_out > 0;
            if (b_fire && (m_out == 0 || bid >= N)) m_err = 1;
            m_out = m_out + int'(aw_fire) - int'(dec);
            if (w_fire) begin
                if (m_sent == m_len) m_active = 0;
                else m_sent++;
            end
            if (aw_fire) m_aw_done = 1;
            if (g >= 0) begin
                m_active = 1; m_aw_done = 0; m_sent = 0; m_owner = g;
                m_len  = int'(cmd_len[g*8 +: 8]);
                m_addr = cmd_addr[g*40 +: 40];
                m_ptr  = (g + 1) % N;
            end
            m_live = 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: drive #1 after posedge, sample at negedge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cmd_valid = '0; cmd_addr = '0; cmd_len = '0;
        pkt_valid = '0; pkt_data = '0;
        awready = 1'b0; wready = 1'b0;
        bid = '0; bresp = '0; bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [15:0] q_ids[$];

    task automatic step_rand();
        logic [N-1:0] hs;
        at_neg();
        hs = cmd_valid & cmd_ready;
        if (awvalid && awready) q_ids.push_back(awid);
        tick();
        for (int i = 0; i < N; i++) begin
            if (hs[i]) cmd_valid[i] = 1'b0;
            if (!cmd_valid[i] && $urandom_range(0, 99) < 30) begin
                cmd_valid[i]          = 1'b1;
                cmd_addr[i*40 +: 40]  = {8'($urandom), $urandom};
                cmd_len[i*8 +: 8]     = 8'($urandom_range(0, 5));
            end
        end
        pkt_valid = N'($urandom);
        pkt_data  = rand_data();
        awready   = ($urandom_range(0, 99) < 60);
        wready    = ($urandom_range(0, 99) < 70);
        bvalid    = 1'b0;
        if (q_ids.size() > 0 && $urandom_range(0, 99) < 40) begin
            bvalid = 1'b1;
            bid    = q_ids.pop_front();
            bresp  = 2'($urandom);
        end
    endtask

    initial begin : p_main
        int beats, last_at, ng, last_cyc;
        int got[5];
        int exp_ord[5];
        bit done, cmd_hs, aw_hs;
        logic [15:0] hid;
        logic [N-1:0] other;
        exp_ord = '{0, 1, 2, 3, 0};

        // Reset: commands present but nothing may be accepted.
        clear_inputs();
        cmd_valid = '1;
        rst_n = 1'b0;
        tick();
        at_neg();
        chk("reset_cmd_ready", cmd_ready, 4'b0000);
        chk("reset_out_cnt", out_cnt, 6'd0);
        tick();

        // T1: single requester 0, len 3.
        do_reset();
        cmd_valid[0] = 1'b1; cmd_addr[39:0] = 40'h00_1234_5678; cmd_len[7:0] = 8'd3;
        awready = 1'b1; wready = 1'b1; pkt_valid = 4'b0001; pkt_data = rand_data();
        at_neg();
        chk("t1_cmd_ready", cmd_ready, 4'b0001);
        chk("t1_no_aw_yet", awvalid, 1'b0);
        tick();
        cmd_valid = '0;
        at_neg();
        chk("t1_awvalid", awvalid, 1'b1);
        chk("t1_awaddr", awaddr, 64'h0000_0004_8D15_9E00);
        chk("t1_awid", awid, 16'h0000);
        chk("t1_awlen", awlen, 8'd3);
        tick();
        beats = 0; last_at = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            at_neg();
            if (wvalid && wready) begin
                beats++;
                if (wlast) begin last_at = beats; done = 1; end
            end
            tick();
            pkt_data = rand_data();
        end
        chk("t1_beats", beats, 4);
        chk("t1_wlast_beat", last_at, 4);
        at_neg();
        chk("t1_out_cnt_1", out_cnt, 6'd1);
        tick();
        bvalid = 1'b1; bid = 16'h0000; bresp = 2'b10;
        at_neg();
        chk("t1_bresp_valid", bresp_valid, 4'b0001);
        chk("t1_bresp", req_bresp, 2'b10);
        tick();
        bvalid = 1'b0;
        at_neg();
        chk("t1_out_cnt_0", out_cnt, 6'd0);
        tick();

        // T2: all requesters always valid, len 0: order and spacing.
        do_reset();
        cmd_valid = '1; cmd_len = '0; awready = 1'b1; wready = 1'b1; pkt_valid = '1;
        ng = 0; last_cyc = -1;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            at_neg();
            aw_hs = awvalid && awready;
            hid   = awid;
            if (cmd_ready != 0) begin
                got[ng] = onehot_idx(cmd_ready);
                if (ng > 0) chk("t2_grant_gap", c - last_cyc, 3);
                last_cyc = c;
                ng++;
            end
            tick();
            bvalid = aw_hs; bid = hid; bresp = 2'b00;
        end
        chk("t2_grant_count", ng, 5);
        for (int k = 0; k < ng; k++) chk("t2_grant_order", got[k], exp_ord[k]);

        // T3: requester 2, len 7, gappy data and backpressure.
        do_reset();
        cmd_valid[2] = 1'b1; cmd_addr[80 +: 40] = 40'hAB_CDEF_0123; cmd_len[16 +: 8] = 8'd7;
        awready = 1'b1;
        beats = 0; last_at = 0; done = 0; cmd_hs = 0; other = '0;
        for (int c = 0; c < 300 && !done; c++) begin
            at_neg();
            if (cmd_ready[2]) cmd_hs = 1;
            if (pkt_valid[2] && pkt_ready[2]) begin
                beats++;
                if (wlast) begin last_at = beats; done = 1; end
            end
            other |= pkt_ready & 4'b1011;
            tick();
            if (cmd_hs) cmd_valid[2] = 1'b0;
            pkt_valid = N'($urandom);
            wready    = 1'($urandom_range(0, 1));
            pkt_data  = rand_data();
        end
        chk("t3_done", done, 1'b1);
        chk("t3_beats", beats, 8);
        chk("t3_wlast_beat", last_at, 8);
        chk("t3_other_ready", other, 4'b0000);

        // T4: outstanding limit of 2.
        do_reset();
        cmd_valid[1] = 1'b1; cmd_len = '0; awready = 1'b1; wready = 1'b1; pkt_valid = 4'b0010;
        repeat (12) tick();
        at_neg();
        chk("t4_out_full", out_cnt, 6'd2);
        chk("t4_stall", cmd_ready, 4'b0000);
        tick();
        bvalid = 1'b1; bid = 16'h0001;
        at_neg();
        chk("t4_stall_b_cycle", cmd_ready, 4'b0000);
        tick();
        bvalid = 1'b0;
        at_neg();
        chk("t4_regrant", cmd_ready, 4'b0010);
        tick();
        bvalid = 1'b1; bid = 16'h0001;
        at_neg();
        chk("t4_aw_with_b", awvalid, 1'b1);
        chk("t4_out_before", out_cnt, 6'd1);
        tick();
        bvalid = 1'b0;
        at_neg();
        chk("t4_out_same", out_cnt, 6'd1);
        tick();

        // T5: bad bid and response with nothing outstanding.
        do_reset();
        cmd_valid[0] = 1'b1; awready = 1'b1; wready = 1'b1; pkt_valid = 4'b0001;
        tick();
        cmd_valid = '0;
        repeat (4) tick();
        at_neg();
        chk("t5_out_1", out_cnt, 6'd1);
        chk("t5_err_clear", err_bad_bid, 1'b0);
        tick();
        bvalid = 1'b1; bid = 16'h0005;
        at_neg();
        chk("t5_badbid_dropped", bresp_valid, 4'b0000);
        tick();
        bvalid = 1'b1; bid = 16'h0000;
        at_neg();
        chk("t5_badbid_err", err_bad_bid, 1'b1);
        chk("t5_badbid_dec", out_cnt, 6'd0);
        chk("t5_empty_dropped", bresp_valid, 4'b0000);
        tick();
        bvalid = 1'b0;
        repeat (3) tick();
        at_neg();
        chk("t5_no_wrap", out_cnt, 6'd0);
        chk("t5_err_sticky", err_bad_bid, 1'b1);
        tick();

        // T6: reset in the middle of a 5-beat burst.
        do_reset();
        cmd_valid[0] = 1'b1; cmd_len[7:0] = 8'd4; awready = 1'b1; wready = 1'b1; pkt_valid = 4'b0001;
        tick();
        cmd_valid = '0;
        tick();
        at_neg();
        chk("t6_beat1", wvalid, 1'b1);
        tick();
        rst_n = 1'b0;
        at_neg();
        chk("t6_wvalid", wvalid, 1'b0);
        chk("t6_awvalid", awvalid, 1'b0);
        chk("t6_out_cnt", out_cnt, 6'd0);
        tick();
        rst_n = 1'b1;
        cmd_valid = 4'b1000;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            at_neg();
            if (cmd_ready != 0) begin
                chk("t6_first_grant", cmd_ready, 4'b1000);
                done = 1;
            end
            tick();
        end
        chk("t6_grant_seen", done, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        q_ids.delete();
        for (int c = 0; c < 3000; c++) step_rand();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
